// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite definitions for the slave-side decoder and the
// response multiplexer.
//   - HTRANS transfer-type encodings and HRESP response codes
//   - slave address map: decode field HADDR[31:24], region base 8'h01
//   - data-phase select record and default-slave FSM state type
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Slave i lives at HADDR[DEC_MSB:DEC_LSB] == REGION_BASE + i
    localparam int unsigned DEC_MSB     = 31;
    localparam int unsigned DEC_LSB     = 24;
    localparam logic [7:0]  REGION_BASE = 8'h01;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } defslv_state_e;

    // Data-phase select: which slave owns the current data phase
    typedef struct packed {
        logic [3:0] idx;
        logic       unmapped;
        logic       active;
    } dsel_t;

    // NONSEQ and SEQ both have HTRANS[1] set
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers transfers to unmapped addresses with the
// two-cycle AHB ERROR response (IDLE -> ERR1 -> ERR2).
//   hclk      in   bus clock
//   hreset    in   synchronous active-high reset
//   hready    in   muxed HREADY (transfer acceptance)
//   err_req   in   address phase is an unmapped NONSEQ/SEQ
//   ready_out out  registered default-slave HREADYOUT
//   resp_out  out  registered default-slave HRESP
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hreset,
    input  logic hready,
    input  logic err_req,
    output logic ready_out,
    output logic resp_out
);

    defslv_state_e state;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= DS_IDLE;
            ready_out <= 1'b1;
            resp_out  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (hready && err_req) begin
                        state     <= DS_ERR1;
                        ready_out <= 1'b0;
                        resp_out  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ready_out <= 1'b1;
                    resp_out  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // Back-to-back unmapped transfer restarts the error pair
                    if (hready && err_req) begin
                        state     <= DS_ERR1;
                        ready_out <= 1'b0;
                        resp_out  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ready_out <= 1'b1;
                        resp_out  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    ready_out <= 1'b1;
                    resp_out  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_response_mux.sv
// ahb_slave_response_mux: AHB-Lite address decoder and slave response mux.
// Optional feature macro: AHB_DEFSLV_ERROR_EN (default slave returns ERROR
// for unmapped NONSEQ/SEQ; otherwise unmapped transfers complete OKAY).
//   HCLK, HRESET          clock, synchronous active-high reset
//   HADDR, HTRANS         address phase from the master multiplexer
//   HSEL                  one-hot combinational slave select
//   HRDATA_S, HREADYOUT_S, HRESP_S   packed per-slave responses
//   HRDATA, HREADY, HRESP muxed response back to masters / slaves
module ahb_slave_response_mux
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP
);

    logic [7:0] region;
    logic       addr_mapped;
    logic [3:0] addr_idx;
    dsel_t      dsel;
    logic       def_ready;
    logic       def_resp;

    assign region = HADDR[DEC_MSB:DEC_LSB];

    // Regions above NUM_SLAVES never match, so they fall out as unmapped
    always_comb begin
        HSEL        = '0;
        addr_mapped = 1'b0;
        addr_idx    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (region == REGION_BASE + 8'(i)) begin
                HSEL[i]     = 1'b1;
                addr_mapped = 1'b1;
                addr_idx    = 4'(i);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel <= '{idx: '0, unmapped: 1'b1, active: 1'b0};
        end else if (HREADY) begin
            dsel <= '{idx: addr_idx, unmapped: !addr_mapped, active: is_active(HTRANS)};
        end
    end

`ifdef AHB_DEFSLV_ERROR_EN
    ahb_default_slave u_default_slave (
        .hclk      (HCLK),
        .hreset    (HRESET),
        .hready    (HREADY),
        .err_req   (!addr_mapped && is_active(HTRANS)),
        .ready_out (def_ready),
        .resp_out  (def_resp)
    );
`else
    assign def_ready = 1'b1;
    assign def_resp  = HRESP_OKAY;
`endif

    always_comb begin
        HRDATA = '0;
        HREADY = def_ready;
        HRESP  = def_resp;
        if (!dsel.unmapped) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (dsel.idx == 4'(i)) begin
                    HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end
    end

    // Low address bits, HTRANS[0] and the data-phase active flag carry no
    // decode/mux information here
    logic unused_bits;
    assign unused_bits = ^{HADDR[DEC_LSB-1:0], HTRANS[0], dsel.active};

endmodule

// File: tb/tb_ahb_slave_response_mux.sv
module tb_ahb_slave_response_mux;
    import ahb_pkg::*;

`ifdef AHB_DEFSLV_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int unsigned NS = 16;
    localparam int unsigned DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic [NS-1:0]     HSEL;
    logic [NS*DW-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S;
    logic [NS-1:0]     HRESP_S;
    logic [DW-1:0]     HRDATA;
    logic              HREADY;
    logic              HRESP;

    ahb_slave_response_mux #(
        .NUM_SLAVES (NS),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (32)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [15:0] hsel;
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle
    always @(negedge HCLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".hsel"},   32'(HSEL),   32'(e.hsel));
            chk({e.name, ".hrdata"}, HRDATA,      e.rdata);
            chk({e.name, ".hready"}, 32'(HREADY), 32'(e.ready));
            chk({e.name, ".hresp"},  32'(HRESP),  32'(e.resp));
        end
    end

    // One bus cycle: drive just after the edge, queue what this cycle must show
    task automatic step(input string nm, input logic rst, input logic [31:0] addr,
                        input logic [1:0] trans, input logic [15:0] rdy,
                        input logic [15:0] e_hsel, input logic [31:0] e_rdata,
                        input logic e_ready, input logic e_resp);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET      = rst;
        HADDR       = addr;
        HTRANS      = trans;
        HREADYOUT_S = rdy;
        HRESP_S     = '0;
        e.name  = nm;
        e.hsel  = e_hsel;
        e.rdata = e_rdata;
        e.ready = e_ready;
        e.resp  = e_resp;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET      = 1'b1;
        HADDR       = '0;
        HTRANS      = HTRANS_IDLE;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < NS; i++)
            HRDATA_S[i*DW +: DW] = (i == 2) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);

        // Reset values
        step("reset1", 1, 32'h0, HTRANS_IDLE, 16'hFFFF, 16'h0000, 32'h0, 1, 0);
        step("reset2", 1, 32'h0, HTRANS_IDLE, 16'hFFFF, 16'h0000, 32'h0, 1, 0);

        // Slave 2 decode and one-cycle data phase
        step("addr_s2", 0, 32'h0300_0010, HTRANS_NONSEQ, 16'hFFFF, 16'h0004, 32'h0, 1, 0);
        step("data_s2", 0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'hDEAD_BEEF, 1, 0);

        // Slave 4 stalls three cycles while address phase targets slave 8
        step("addr_s4",  0, 32'h0500_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h0010, 32'h0, 1, 0);
        step("s4_wait1", 0, 32'h0900_0000, HTRANS_NONSEQ, 16'hFFEF, 16'h0100, 32'hA000_0004, 0, 0);
        step("s4_wait2", 0, 32'h0900_0000, HTRANS_NONSEQ, 16'hFFEF, 16'h0100, 32'hA000_0004, 0, 0);
        step("s4_wait3", 0, 32'h0900_0000, HTRANS_NONSEQ, 16'hFFEF, 16'h0100, 32'hA000_0004, 0, 0);
        step("s4_done",  0, 32'h0900_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h0100, 32'hA000_0004, 1, 0);
        step("data_s8",  0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'hA000_0008, 1, 0);

        // IDLE to unmapped address: no error cycles
        step("idle_unm_a", 0, 32'h2000_0000, HTRANS_IDLE, 16'hFFFF, 16'h0000, 32'h0, 1, 0);
        step("idle_unm_d", 0, 32'h0,         HTRANS_IDLE, 16'hFFFF, 16'h0000, 32'h0, 1, 0);

        // Unmapped NONSEQ then back-to-back SEQ
        step("unm_addr", 0, 32'h2000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h0000, 32'h0, 1, 0);
        step("unm_err1", 0, 32'h2000_0000, HTRANS_SEQ,    16'hFFFF, 16'h0000, 32'h0, !ERR_EN, ERR_EN);
        step("unm_err2", 0, 32'h2000_0000, HTRANS_SEQ,    16'hFFFF, 16'h0000, 32'h0, 1, ERR_EN);
        step("b2b_err1", 0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, !ERR_EN, ERR_EN);
        step("b2b_err2", 0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, 1, ERR_EN);

        // Reset asserted while in ERR1
        step("rst_addr", 0, 32'h2000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h0000, 32'h0, 1, 0);
        step("rst_err1", 1, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, !ERR_EN, ERR_EN);
        step("rst_post", 0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, 1, 0);
        step("rst_idle", 0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, 1, 0);

        // Decode boundaries: 8'h10 -> slave 15, 8'h01 -> slave 0, 8'h11 unmapped
        step("top_addr",  0, 32'h1000_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h8000, 32'h0, 1, 0);
        step("bot_addr",  0, 32'h0100_0000, HTRANS_NONSEQ, 16'hFFFF, 16'h0001, 32'hA000_000F, 1, 0);
        step("bot_data",  0, 32'h0,         HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'hA000_0000, 1, 0);
        step("above_max", 0, 32'h1100_0000, HTRANS_IDLE,   16'hFFFF, 16'h0000, 32'h0, 1, 0);

        @(negedge HCLK);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
